// File: rtl/tube_pkg.sv
// Shared types for the tube scroller: grid geometry, column type and speed select.
package tube_pkg;

  localparam int GRID_W = 16;
  localparam int GRID_H = 16;

  typedef logic [GRID_H-1:0] column_t;

  typedef enum logic [1:0] {SPD_NORM, SPD_FAST, SPD_IMP} speed_e;

  // sw1 outranks sw2
  function automatic speed_e speed_sel(input logic sw1, input logic sw2);
    if (sw1)      return SPD_FAST;
    else if (sw2) return SPD_IMP;
    else          return SPD_NORM;
  endfunction

endpackage

// File: rtl/tube_tick_div.sv
// Scroll-step divider: counts run cycles and fires step once per period.
// Changing period mid-count keeps cnt, so an overshoot steps on the next run cycle.
module tube_tick_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic [31:0] period,
  output logic        step
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (reset) begin
      cnt_d = '0;
    end else if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q >= period - 32'd1) begin
        step  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tube_scroller.sv
// Scrolling tube grid: shifts a new column in at column 0 each step.
// Define TUBE_SCROLLER_SCORE_EN to count tubes passing the bird column.
module tube_scroller
  import tube_pkg::*;
#(
  parameter int unsigned TICK_NORM = 25_000_000,
  parameter int unsigned TICK_FAST = 12_500_000,
  parameter int unsigned TICK_IMP  = 6_250_000,
  parameter int          BIRD_COL  = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         clear,
  input  logic         sw1,
  input  logic         sw2,
  input  logic [15:0]  col_in,
  output logic [255:0] field_o,
  output logic [15:0]  line_o,
  output logic         tick_o,
  output logic [7:0]   score_o
);

  if (BIRD_COL < 0 || BIRD_COL > GRID_W - 2) begin : g_bad_bird
    $error("BIRD_COL must lie in 0..14");
  end

  logic [31:0] period;
  logic        step;

  always_comb begin
    period = TICK_NORM;
    case (speed_sel(sw1, sw2))
      SPD_FAST: period = TICK_FAST;
      SPD_IMP:  period = TICK_IMP;
      default:  period = TICK_NORM;
    endcase
  end

  tube_tick_div u_div (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .clear  (clear),
    .period (period),
    .step   (step)
  );

  column_t [GRID_W-1:0] grid_q, grid_d;
  logic                 tick_q, tick_d;

  // step is already low under reset/clear/!run, so clear needs no extra gating
  always_comb begin
    grid_d = grid_q;
    tick_d = step;
    if (clear)     grid_d = '0;
    else if (step) grid_d = {grid_q[GRID_W-2:0], column_t'(col_in)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grid_q <= '0;
      tick_q <= 1'b0;
    end else begin
      grid_q <= grid_d;
      tick_q <= tick_d;
    end
  end

  assign field_o = grid_q;
  assign tick_o  = tick_q;

  always_comb begin
    line_o = '0;
    for (int i = 0; i < GRID_W; i++) line_o[i] = grid_q[i][GRID_H-1];
  end

`ifdef TUBE_SCROLLER_SCORE_EN
  logic [7:0] score_q, score_d;

  // leading edge of a tube at the bird column scores once regardless of width
  always_comb begin
    score_d = score_q;
    if (step && grid_q[BIRD_COL] != '0 && grid_q[BIRD_COL+1] == '0 &&
        score_q != 8'hFF)
      score_d = score_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) score_q <= '0;
    else       score_q <= score_d;
  end

  assign score_o = score_q;
`else
  assign score_o = '0;
`endif

endmodule

// File: tb/tb_tube_scroller.sv
// Directed bench for tube_scroller with short tick periods (4/2/1, bird at 12).
module tb_tube_scroller;

`ifdef TUBE_SCROLLER_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, run, clear, sw1, sw2;
  logic [15:0]  col_in;
  logic [255:0] field_o;
  logic [15:0]  line_o;
  logic         tick_o;
  logic [7:0]   score_o;

  int checks = 0;
  int errors = 0;
  int n;

  tube_scroller #(
    .TICK_NORM (4),
    .TICK_FAST (2),
    .TICK_IMP  (1),
    .BIRD_COL  (12)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .run     (run),
    .clear   (clear),
    .sw1     (sw1),
    .sw2     (sw2),
    .col_in  (col_in),
    .field_o (field_o),
    .line_o  (line_o),
    .tick_o  (tick_o),
    .score_o (score_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        run;
    logic [15:0] col_in;
    logic        exp_tick;
    logic [15:0] exp_line;
    logic [15:0] exp_col0;
    logic [15:0] exp_col1;
  } vec_t;

  vec_t vt[8];

  function automatic logic [7:0] sc(input int k);
    return SCORE_EN ? 8'(k) : 8'd0;
  endfunction

  function automatic logic [15:0] colv(input int i);
    return field_o[16*i +: 16];
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int max, output int cnt);
    cnt = 0;
    do begin
      cyc();
      cnt++;
    end while (!tick_o && cnt < max);
    if (!tick_o) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: no tick within %0d cycles", max);
    end
  endtask

  initial begin
    // col_in outside a step cycle carries junk to prove it is ignored
    vt[0] = '{1'b1, 16'h7E7E, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vt[1] = '{1'b1, 16'h7E7E, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vt[2] = '{1'b1, 16'h7E7E, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vt[3] = '{1'b1, 16'h8183, 1'b1, 16'h0001, 16'h8183, 16'h0000};
    vt[4] = '{1'b1, 16'hFFFF, 1'b0, 16'h0001, 16'h8183, 16'h0000};
    vt[5] = '{1'b1, 16'hFFFF, 1'b0, 16'h0001, 16'h8183, 16'h0000};
    vt[6] = '{1'b1, 16'hFFFF, 1'b0, 16'h0001, 16'h8183, 16'h0000};
    vt[7] = '{1'b1, 16'h0000, 1'b1, 16'h0002, 16'h0000, 16'h8183};

    reset = 1'b1; run = 1'b0; clear = 1'b0; sw1 = 1'b0; sw2 = 1'b0; col_in = '0;
    cyc(); cyc();
    chk("reset tick", tick_o, 0);
    chk("reset field", field_o, 0);
    chk("reset line", line_o, 0);
    chk("reset score", score_o, 0);
    reset = 1'b0;

    // first two scroll steps, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      run = vt[i].run; col_in = vt[i].col_in;
      cyc();
      chk($sformatf("vec%0d tick", i), tick_o, vt[i].exp_tick);
      chk($sformatf("vec%0d line", i), line_o, vt[i].exp_line);
      chk($sformatf("vec%0d col0", i), colv(0), vt[i].exp_col0);
      chk($sformatf("vec%0d col1", i), colv(1), vt[i].exp_col1);
    end

    // 12 more steps walk the column to col13, scoring as it leaves col12
    col_in = '0;
    for (int k = 0; k < 12; k++) begin
      wait_tick(8, n);
      chk($sformatf("norm interval %0d", k), n, 4);
    end
    chk("pass line", line_o, 16'h2000);
    chk("pass field", field_o, 256'h8183 << (16*13));
    chk("pass score", score_o, sc(1));

    // clear keeps score; then a two-column tube scores only once
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear field", field_o, 0);
    chk("clear tick", tick_o, 0);
    chk("clear score", score_o, sc(1));
    col_in = 16'h8001;
    wait_tick(8, n);
    chk("post-clear interval", n, 4);
    wait_tick(8, n);
    col_in = '0;
    for (int k = 0; k < 14; k++) wait_tick(8, n);
    chk("wide line", line_o, 16'hC000);
    chk("wide score", score_o, sc(2));
    wait_tick(8, n);
    chk("discard line", line_o, 16'h8000);
    chk("wide score hold", score_o, sc(2));

    // speed switch with cnt=2 in normal: already past fast period-1
    cyc(); cyc();
    chk("pre-switch tick", tick_o, 0);
    sw1 = 1'b1;
    cyc();
    chk("fast switch tick", tick_o, 1);
    wait_tick(8, n); chk("fast interval a", n, 2);
    wait_tick(8, n); chk("fast interval b", n, 2);
    sw1 = 1'b0; sw2 = 1'b1;
    wait_tick(8, n); chk("imp interval a", n, 1);
    wait_tick(8, n); chk("imp interval b", n, 1);
    sw1 = 1'b1;
    wait_tick(8, n); chk("sw1 priority interval", n, 2);
    sw1 = 1'b0; sw2 = 1'b0;
    wait_tick(8, n); chk("back to norm interval", n, 4);

    // run=0 freeze mid-count
    clear = 1'b1; cyc(); clear = 1'b0;
    col_in = 16'hA5A5;
    wait_tick(8, n);
    chk("load interval", n, 4);
    col_in = '0;
    cyc(); cyc();
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk($sformatf("frozen tick %0d", k), tick_o, 0);
    end
    chk("frozen field", field_o, 256'hA5A5);
    chk("frozen score", score_o, sc(2));
    run = 1'b1;
    wait_tick(8, n);
    chk("resume interval", n, 2);
    chk("resume col1", colv(1), 16'hA5A5);
    chk("resume col0", colv(0), 16'h0000);

    // clear landing on a step cycle
    cyc(); cyc(); cyc();
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clear-on-step tick", tick_o, 0);
    chk("clear-on-step field", field_o, 0);
    chk("clear-on-step score", score_o, sc(2));
    col_in = 16'hFFFF;
    wait_tick(8, n);
    chk("after clear interval", n, 4);
    chk("after clear col0", colv(0), 16'hFFFF);
    // reset with clear, on a step cycle: no shift, score wiped
    cyc(); cyc(); cyc();
    reset = 1'b1; clear = 1'b1; cyc(); reset = 1'b0; clear = 1'b0;
    chk("reset-on-step field", field_o, 0);
    chk("reset-on-step tick", tick_o, 0);
    chk("reset-on-step score", score_o, 0);

    // saturation: period 1, alternating columns -> one pass every two steps
    sw2 = 1'b1;
    for (int j = 0; j < 600; j++) begin
      col_in = (j % 2 == 0) ? 16'h0001 : 16'h0000;
      cyc();
      if (j == 199) chk("score after 200 steps", score_o, sc(94));
    end
    chk("score saturated", score_o, sc(255));
    chk("sat tick every cycle", tick_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
